// File: rtl/serial_subtractor.sv
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial two's-complement subtractor (diff = a - b), LSB first,
//            start/done handshake. Optional zero/negative flags under the
//            SERIAL_SUB_FLAGS_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
`ifdef SERIAL_SUB_FLAGS_EN
    output logic             zero,
    output logic             negative,
`endif
    output logic             overflow
);

    localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_sa;
    logic [WIDTH-1:0]     r_sb;
    logic [WIDTH-2:0]     r_res;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_bw;
    logic                 r_a_msb;
    logic                 r_b_msb;
    logic                 r_nz;

    logic                 w_d;
    logic                 w_bw_next;
    logic [WIDTH-1:0]     w_res_next;

    // Single full-subtractor cell operating on the current LSBs.
    assign w_d        = r_sa[0] ^ r_sb[0] ^ r_bw;
    assign w_bw_next  = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_bw);
    assign w_res_next = {w_d, r_res};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_sa       <= '0;
            r_sb       <= '0;
            r_res      <= '0;
            r_cnt      <= '0;
            r_bw       <= 1'b0;
            r_a_msb    <= 1'b0;
            r_b_msb    <= 1'b0;
            r_nz       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
            zero       <= 1'b0;
            negative   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
                        r_bw    <= 1'b0;
                        r_cnt   <= '0;
                        r_nz    <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_bw  <= w_bw_next;
                    r_res <= w_res_next[WIDTH-1:1];
                    r_nz  <= r_nz | w_d;
                    if (r_cnt == c_LAST) begin
                        // The last computed bit is the result MSB, so the
                        // flags use w_d directly rather than waiting a cycle.
                        r_state    <= S_DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        diff       <= w_res_next;
                        borrow_out <= w_bw_next;
                        overflow   <= (r_a_msb != r_b_msb) & (w_d != r_a_msb);
`ifdef SERIAL_SUB_FLAGS_EN
                        zero       <= ~(r_nz | w_d);
                        negative   <= w_d;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module   : tb_serial_subtractor
// Brief    : Self-checking bench for serial_subtractor (WIDTH=8), directed and
//            random operands against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         overflow;
`ifdef SERIAL_SUB_FLAGS_EN
    logic         zero;
    logic         negative;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Expected values of the most recent completed operation.
    logic [W-1:0] m_diff = '0;
    logic         m_bor  = 1'b0;
    logic         m_ovf  = 1'b0;

    serial_subtractor #(.WIDTH(W)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
`ifdef SERIAL_SUB_FLAGS_EN
        .zero       (zero),
        .negative   (negative),
`endif
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb_v);
        int ua, ub, sa, sb, sr;
        ua = int'(ta);
        ub = int'(tb_v);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        sr = sa - sb;
        m_diff = W'((ua - ub + 256) % 256);
        m_bor  = (ua < ub);
        m_ovf  = (sr > 127) || (sr < -128);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_diff"}, 32'(diff), 32'(m_diff));
        chk({tag, "_borrow"}, 32'(borrow_out), 32'(m_bor));
        chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
`ifdef SERIAL_SUB_FLAGS_EN
        chk({tag, "_zero"}, 32'(zero), 32'(m_diff == '0));
        chk({tag, "_neg"}, 32'(negative), 32'(m_diff[W-1]));
`endif
    endtask

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input bit inject);
        int edges;
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        chk("busy_e0", 32'(busy), 32'd1);
        chk("done_e0", 32'(done), 32'd0);
        edges = 0;
        while (!done && edges < 20) begin
            if (inject && edges == 2) begin
                start = 1'b1;
                a     = W'($urandom);
                b     = W'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            edges++;
            if (!done) begin
                chk("hold_diff", 32'(diff), 32'(m_diff));
                chk("busy_run", 32'(busy), 32'd1);
            end
        end
        start = 1'b0;
        chk("latency", 32'(edges), 32'(W));
        model(ta, tb_v);
        chk("busy_done", 32'(busy), 32'd0);
        check_outputs("res");
        @(posedge clk);
        #1;
        chk("done_clr", 32'(done), 32'd0);
        check_outputs("hold");
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        check_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_done", 32'(done), 32'd0);

        do_op(8'd5,   8'd3,   1'b0);
        do_op(8'd3,   8'd5,   1'b0);
        do_op(8'h80,  8'h01,  1'b0);
        do_op(8'h7F,  8'hFF,  1'b0);
        do_op(8'h2A,  8'h2A,  1'b0);
        do_op(8'h00,  8'h80,  1'b0);
        do_op(8'h11,  8'h22,  1'b1);

        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom_range(0, 255));
            rb = (i % 7 == 0) ? ra : W'($urandom_range(0, 255));
            do_op(ra, rb, (i % 5 == 0));
        end

        // Asynchronous abort in the middle of an operation.
        @(negedge clk);
        a     = 8'h33;
        b     = 8'h44;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        m_diff = '0;
        m_bor  = 1'b0;
        m_ovf  = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        check_outputs("abort");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            chk("abort_nodone", 32'(done), 32'd0);
        end
        do_op(8'd9, 8'd4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
